// File: rtl/fwft_read_stage.sv
// fwft_read_stage
//   Read-side consumer of the FIFO pointer control. Issues read requests,
//   captures the RAM read data one clock after each accepted request and
//   presents it as a first-word-fall-through valid/ready stream. A 2-entry
//   buffer (output register + skid register) sustains one word per clock
//   under continuous ready, and absorbs the in-flight word when the sink stalls.
//
// Ports
//   r_clk_i       read-domain clock, all logic on posedge
//   rst_i         synchronous active-high reset
//   r_empty_i     empty flag from read pointer control
//   r_req_o       read request to pointer control (combinational)
//   rd_data_i     RAM read data, valid one clock after an accepted request
//   dout_o        registered output word (always the oldest held word)
//   dout_valid_o  dout_o holds a valid word
//   dout_ready_i  sink accepts dout_o this clock
//   word_cnt_o    words delivered (only when RD_STATS_EN is defined, else 0)
//
// Build option
//   RD_STATS_EN   builds the 32-bit delivered-word counter behind word_cnt_o

module fwft_read_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk_i,
    input  logic                  rst_i,
    input  logic                  r_empty_i,
    output logic                  r_req_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i,
    output logic [31:0]           word_cnt_o
);

    // Encoding equals buffer occupancy, so the state doubles as the count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  infl_q;
    logic [DATA_WIDTH-1:0] skid_q, skid_d, out_d;
    logic                  pop;
    logic [2:0]            level;

    assign dout_valid_o = (state_q != EMPTY);
    assign pop          = dout_valid_o & dout_ready_i;

    // Words held plus the word in flight must stay within the two buffer
    // slots after this clock's pop; written as level < 2 + pop to avoid
    // a negative intermediate.
    assign level   = {1'b0, state_q} + {2'b00, infl_q};
    assign r_req_o = ~rst_i & ~r_empty_i & (level < (3'd2 + {2'b00, pop}));

    always_comb begin
        state_d = state_q;
        out_d   = dout_o;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (infl_q) begin
                    out_d   = rd_data_i;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (infl_q && pop) begin
                    out_d = rd_data_i;
                end else if (infl_q) begin
                    skid_d  = rd_data_i;
                    state_d = TWO;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // Skid always holds the younger word, so it is the next
                // one to reach the output register.
                if (pop) begin
                    out_d = skid_q;
                    if (infl_q) begin
                        skid_d = rd_data_i;
                    end else begin
                        state_d = ONE;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge r_clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            infl_q  <= 1'b0;
            dout_o  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            infl_q  <= r_req_o;
            dout_o  <= out_d;
            skid_q  <= skid_d;
        end
    end

`ifdef RD_STATS_EN
    logic [31:0] cnt_q;

    always_ff @(posedge r_clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (pop) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign word_cnt_o = cnt_q;
`else
    assign word_cnt_o = '0;
`endif

endmodule
